calc_key_entry: RTL and testbench

- Operand-entry controller directly upstream of the BCD add/subtract ALU.
- Accepts one decoded keypad code per valid pulse.
- Shifts decimal digits into two 4-digit BCD operand registers, records the operator, and drives reg1/reg2/regop into the ALU.
- On '=' it waits one cycle for the combinational ALU to settle, then latches res/sign/ovf into a display register.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_operand_reg.sv | 40 ++++
 rtl/calc_key_entry.sv | 140 ++++++++++++++
 tb/tb_calc_key_entry.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, state encoding and defaults for the calculator entry path
package calc_pkg;

   localparam int DIGITS_DEFAULT = 4;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_EQ  = 4'hC;
   localparam logic [3:0] KEY_CLR = 4'hD;

   localparam logic [1:0] S_OP1  = 2'd0;
   localparam logic [1:0] S_OP2  = 2'd1;
   localparam logic [1:0] S_EVAL = 2'd2;
   localparam logic [1:0] S_SHOW = 2'd3;

   function automatic logic is_digit(input logic [3:0] key);
      return key <= 4'd9;
   endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// rtl/calc_operand_reg.sv - BCD operand shift register with saturating digit counter
module calc_operand_reg #(
   parameter int DIGITS = 4,
   parameter int CW     = $clog2(DIGITS + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_load_val,
   input  logic [CW-1:0]         i_load_cnt,
   input  logic                  i_shift,
   input  logic [3:0]            i_digit,
   output logic [4*DIGITS-1:0]   o_value,
   output logic [CW-1:0]         o_cnt
);

   localparam logic [CW-1:0] FULL = CW'(DIGITS);

   logic [4*DIGITS-1:0] r_value;
   logic [CW-1:0]       r_cnt;

   // Once the register is full, further digits are silently dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_value <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
         r_cnt   <= i_load_cnt;
      end else if (i_shift && (r_cnt < FULL)) begin
         r_value <= {r_value[4*DIGITS-5:0], i_digit};
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign o_value = r_value;
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - keypad operand/operator entry FSM feeding the BCD ALU and display
module calc_key_entry
   import calc_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [3:0]            i_key_code,
   input  logic                  i_key_valid,
   input  logic [4*DIGITS-1:0]   i_alu_res,
   input  logic                  i_alu_ovf,
   input  logic                  i_alu_sign,
   output logic [4*DIGITS-1:0]   o_reg1,
   output logic [4*DIGITS-1:0]   o_reg2,
   output logic                  o_regop,
   output logic                  o_busy,
   output logic [4*DIGITS-1:0]   o_disp_bcd,
   output logic                  o_disp_neg,
   output logic                  o_disp_ovf
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   logic [1:0]   r_state;
   logic         r_regop;
   logic [W-1:0] r_res_q;
   logic         r_neg_q;
   logic         r_ovf_q;

   logic         w_dig, w_op, w_eq, w_clr, w_chain, w_full_clr;
   logic         w_r1_shift, w_r1_load, w_r2_shift, w_r2_clr;
   logic [W-1:0] w_r1_load_val;
   logic [CW-1:0] w_r1_load_cnt;
   logic [W-1:0] w_reg1, w_reg2;
   logic [CW-1:0] w_cnt1, w_cnt2;

   assign w_dig = i_key_valid && is_digit(i_key_code);
   assign w_op  = i_key_valid && ((i_key_code == KEY_ADD) || (i_key_code == KEY_SUB));
   assign w_eq  = i_key_valid && (i_key_code == KEY_EQ);
   assign w_clr = i_key_valid && (i_key_code == KEY_CLR);

   // Keys arriving during the evaluation cycle are dropped, clear included.
   assign w_full_clr = w_clr && (r_state != S_EVAL);
   assign w_chain    = (r_state == S_SHOW) && w_op && !r_neg_q && !r_ovf_q;

   assign w_r1_shift    = (r_state == S_OP1) && w_dig;
   assign w_r1_load     = ((r_state == S_SHOW) && w_dig) || w_chain;
   assign w_r1_load_val = w_dig ? {{(W-4){1'b0}}, i_key_code} : r_res_q;
   assign w_r1_load_cnt = w_dig ? CW'(1) : CW'(DIGITS);

   assign w_r2_shift = (r_state == S_OP2) && w_dig;
   assign w_r2_clr   = w_full_clr || ((r_state == S_OP1) && w_op) ||
                       ((r_state == S_SHOW) && w_dig) || w_chain;

   calc_operand_reg #(.DIGITS(DIGITS)) u_reg1 (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (w_full_clr),
      .i_load     (w_r1_load),
      .i_load_val (w_r1_load_val),
      .i_load_cnt (w_r1_load_cnt),
      .i_shift    (w_r1_shift),
      .i_digit    (i_key_code),
      .o_value    (w_reg1),
      .o_cnt      (w_cnt1)
   );

   calc_operand_reg #(.DIGITS(DIGITS)) u_reg2 (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (w_r2_clr),
      .i_load     (1'b0),
      .i_load_val ({W{1'b0}}),
      .i_load_cnt ({CW{1'b0}}),
      .i_shift    (w_r2_shift),
      .i_digit    (i_key_code),
      .o_value    (w_reg2),
      .o_cnt      (w_cnt2)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || w_full_clr) begin
         r_state <= S_OP1;
         r_regop <= 1'b1;
         r_res_q <= '0;
         r_neg_q <= 1'b0;
         r_ovf_q <= 1'b0;
      end else begin
         case (r_state)
            S_OP1: begin
               if (w_op) begin
                  r_regop <= (i_key_code == KEY_ADD);
                  r_state <= S_OP2;
               end
            end
            S_OP2: begin
               if (w_op) begin
                  r_regop <= (i_key_code == KEY_ADD);
               end else if (w_eq) begin
                  r_state <= S_EVAL;
               end
            end
            S_EVAL: begin
               // Sign only means something for subtract, overflow only for add.
               r_res_q <= i_alu_res;
               r_neg_q <= i_alu_sign & ~r_regop;
               r_ovf_q <= i_alu_ovf & r_regop;
               r_state <= S_SHOW;
            end
            default: begin
               if (w_dig) begin
                  r_state <= S_OP1;
               end else if (w_chain) begin
                  r_regop <= (i_key_code == KEY_ADD);
                  r_state <= S_OP2;
               end
            end
         endcase
      end
   end

   always_comb begin
      o_disp_bcd = w_reg1;
      case (r_state)
         S_OP2:   o_disp_bcd = (w_cnt2 == '0) ? w_reg1 : w_reg2;
         S_SHOW:  o_disp_bcd = r_res_q;
         default: o_disp_bcd = w_reg1;
      endcase
   end

   assign o_disp_neg = (r_state == S_SHOW) && r_neg_q;
   assign o_disp_ovf = (r_state == S_SHOW) && r_ovf_q;
   assign o_busy     = (r_state == S_EVAL);
   assign o_reg1     = w_reg1;
   assign o_reg2     = w_reg2;
   assign o_regop    = r_regop;

endmodule

// File: tb/tb_calc_key_entry.sv
// tb/tb_calc_key_entry.sv - self-checking bench for calc_key_entry with a behavioural BCD ALU
module tb_calc_key_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        key_valid = 1'b0;
   logic [15:0] alu_res;
   logic        alu_ovf;
   logic        alu_sign;
   logic [15:0] reg1, reg2, disp_bcd;
   logic        regop, busy, disp_neg, disp_ovf;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   calc_key_entry #(.DIGITS(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_key_code (key_code),
      .i_key_valid(key_valid),
      .i_alu_res  (alu_res),
      .i_alu_ovf  (alu_ovf),
      .i_alu_sign (alu_sign),
      .o_reg1     (reg1),
      .o_reg2     (reg2),
      .o_regop    (regop),
      .o_busy     (busy),
      .o_disp_bcd (disp_bcd),
      .o_disp_neg (disp_neg),
      .o_disp_ovf (disp_ovf)
   );

   function automatic int bcd2int(input logic [15:0] b);
      int v = 0;
      for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] b = '0;
      int t = v;
      for (int i = 0; i < 4; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction

   int alu_a, alu_b, alu_s;
   always_comb begin
      alu_a = bcd2int(reg1);
      alu_b = bcd2int(reg2);
      alu_s = 0;
      alu_ovf = 1'b0;
      alu_sign = 1'b0;
      if (regop) begin
         alu_s = alu_a + alu_b;
         alu_ovf = (alu_s > 9999);
         alu_s = alu_s % 10000;
      end else if (alu_a >= alu_b) begin
         alu_s = alu_a - alu_b;
      end else begin
         alu_s = alu_b - alu_a;
         alu_sign = 1'b1;
      end
      alu_res = int2bcd(alu_s);
   end

   typedef struct {
      logic        rst;
      logic        kv;
      logic [3:0]  key;
      logic [15:0] r1;
      logic [15:0] r2;
      logic        op;
      logic        busy;
      logic [15:0] disp;
      logic        neg;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   task automatic tv(input logic r, input logic kv, input logic [3:0] k,
                     input logic [15:0] r1, input logic [15:0] r2, input logic op,
                     input logic bz, input logic [15:0] d, input logic ng, input logic ov);
      vec_t v;
      v.rst = r; v.kv = kv; v.key = k; v.r1 = r1; v.r2 = r2; v.op = op;
      v.busy = bz; v.disp = d; v.neg = ng; v.ovf = ov;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic press(input logic [3:0] k);
      key_code = k;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   initial begin
      vec_t e;
      int n;

      // reset
      tv(1,0,4'h0, 16'h0000,16'h0000,1,0,16'h0000,0,0);
      // 12 + 34
      tv(0,1,4'h1, 16'h0001,16'h0000,1,0,16'h0001,0,0);
      tv(0,1,4'h2, 16'h0012,16'h0000,1,0,16'h0012,0,0);
      tv(0,1,4'hA, 16'h0012,16'h0000,1,0,16'h0012,0,0);
      tv(0,1,4'h3, 16'h0012,16'h0003,1,0,16'h0003,0,0);
      tv(0,1,4'h4, 16'h0012,16'h0034,1,0,16'h0034,0,0);
      tv(0,1,4'hC, 16'h0012,16'h0034,1,1,16'h0012,0,0);
      tv(0,0,4'h0, 16'h0012,16'h0034,1,0,16'h0046,0,0);
      tv(0,1,4'hD, 16'h0000,16'h0000,1,0,16'h0000,0,0);
      // 3 - 8 gives -5; '+' and '=' ignored afterwards
      tv(0,1,4'h3, 16'h0003,16'h0000,1,0,16'h0003,0,0);
      tv(0,1,4'hB, 16'h0003,16'h0000,0,0,16'h0003,0,0);
      tv(0,1,4'h8, 16'h0003,16'h0008,0,0,16'h0008,0,0);
      tv(0,1,4'hC, 16'h0003,16'h0008,0,1,16'h0003,0,0);
      tv(0,0,4'h0, 16'h0003,16'h0008,0,0,16'h0005,1,0);
      tv(0,1,4'hA, 16'h0003,16'h0008,0,0,16'h0005,1,0);
      tv(0,1,4'hC, 16'h0003,16'h0008,0,0,16'h0005,1,0);
      tv(0,1,4'hD, 16'h0000,16'h0000,1,0,16'h0000,0,0);
      // saturation and ignored keys in S_OP1
      tv(0,1,4'h1, 16'h0001,16'h0000,1,0,16'h0001,0,0);
      tv(0,1,4'h2, 16'h0012,16'h0000,1,0,16'h0012,0,0);
      tv(0,1,4'h3, 16'h0123,16'h0000,1,0,16'h0123,0,0);
      tv(0,1,4'h4, 16'h1234,16'h0000,1,0,16'h1234,0,0);
      tv(0,1,4'h5, 16'h1234,16'h0000,1,0,16'h1234,0,0);
      tv(0,1,4'hC, 16'h1234,16'h0000,1,0,16'h1234,0,0);
      tv(0,1,4'hE, 16'h1234,16'h0000,1,0,16'h1234,0,0);
      tv(0,0,4'h7, 16'h1234,16'h0000,1,0,16'h1234,0,0);
      tv(0,1,4'hD, 16'h0000,16'h0000,1,0,16'h0000,0,0);
      // 9876 + 200 overflows; '-' ignored, digit restarts entry
      tv(0,1,4'h9, 16'h0009,16'h0000,1,0,16'h0009,0,0);
      tv(0,1,4'h8, 16'h0098,16'h0000,1,0,16'h0098,0,0);
      tv(0,1,4'h7, 16'h0987,16'h0000,1,0,16'h0987,0,0);
      tv(0,1,4'h6, 16'h9876,16'h0000,1,0,16'h9876,0,0);
      tv(0,1,4'hA, 16'h9876,16'h0000,1,0,16'h9876,0,0);
      tv(0,1,4'h2, 16'h9876,16'h0002,1,0,16'h0002,0,0);
      tv(0,1,4'h0, 16'h9876,16'h0020,1,0,16'h0020,0,0);
      tv(0,1,4'h0, 16'h9876,16'h0200,1,0,16'h0200,0,0);
      tv(0,1,4'hC, 16'h9876,16'h0200,1,1,16'h9876,0,0);
      tv(0,0,4'h0, 16'h9876,16'h0200,1,0,16'h0076,0,1);
      tv(0,1,4'hB, 16'h9876,16'h0200,1,0,16'h0076,0,1);
      tv(0,1,4'h7, 16'h0007,16'h0000,1,0,16'h0007,0,0);
      tv(0,1,4'hD, 16'h0000,16'h0000,1,0,16'h0000,0,0);
      // 5 + 5 = 10, chain with operator replace: 10 - 3 = 7; key during eval dropped
      tv(0,1,4'h5, 16'h0005,16'h0000,1,0,16'h0005,0,0);
      tv(0,1,4'hA, 16'h0005,16'h0000,1,0,16'h0005,0,0);
      tv(0,1,4'h5, 16'h0005,16'h0005,1,0,16'h0005,0,0);
      tv(0,1,4'hC, 16'h0005,16'h0005,1,1,16'h0005,0,0);
      tv(0,0,4'h0, 16'h0005,16'h0005,1,0,16'h0010,0,0);
      tv(0,1,4'hA, 16'h0010,16'h0000,1,0,16'h0010,0,0);
      tv(0,1,4'hB, 16'h0010,16'h0000,0,0,16'h0010,0,0);
      tv(0,1,4'h3, 16'h0010,16'h0003,0,0,16'h0003,0,0);
      tv(0,1,4'hC, 16'h0010,16'h0003,0,1,16'h0010,0,0);
      tv(0,1,4'h9, 16'h0010,16'h0003,0,0,16'h0007,0,0);
      tv(0,1,4'hD, 16'h0000,16'h0000,1,0,16'h0000,0,0);
      // rst wins over a same-cycle digit in S_OP2
      tv(0,1,4'h1, 16'h0001,16'h0000,1,0,16'h0001,0,0);
      tv(0,1,4'hA, 16'h0001,16'h0000,1,0,16'h0001,0,0);
      tv(0,1,4'h2, 16'h0001,16'h0002,1,0,16'h0002,0,0);
      tv(1,1,4'h5, 16'h0000,16'h0000,1,0,16'h0000,0,0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         key_valid = vecs[i].kv;
         key_code = vecs[i].key;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("vec%0d r1/r2/op/busy/disp/neg/ovf", i),
               64'({reg1, reg2, regop, busy, disp_bcd, disp_neg, disp_ovf}),
               64'({e.r1, e.r2, e.op, e.busy, e.disp, e.neg, e.ovf}));
      end
      rst = 1'b0;
      key_valid = 1'b0;

      // 4 - 4: busy must last exactly one cycle, zero result is not negative
      press(4'h4);
      press(4'hB);
      press(4'h4);
      press(4'hC);
      n = 0;
      for (int c = 0; c < 5 && busy; c++) begin
         n++;
         @(posedge clk);
         #1;
      end
      check("busy_cycles", 64'(n), 64'd1);
      check("sub_zero_disp", 64'(disp_bcd), 64'h0000);
      check("sub_zero_neg_ovf", 64'({disp_neg, disp_ovf}), 64'b00);
      check("sub_zero_regop", 64'(regop), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
